serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit binary subtractor; computes diff = a - b, LSB first, one bit per clock.
- Uses a single full-subtractor cell and a registered borrow. It is the inverse-operation counterpart of the lab full-adder cell.
- Provides a parallel result with borrow-out, plus a serial difference stream for downstream serial consumers.
- Used by lab datapaths that trade area for latency.

Parameters:
- WIDTH, 8, operand and result width in bits (legal 2..32).

Ports:
- clk, input, 1, rising-edge clock; the block's only clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request; sampled only in IDLE.
- a, input, WIDTH, minuend; captured on the accepted start edge.
- b, input, WIDTH, subtrahend; captured on the accepted start edge.
- busy, output, 1, high in RUN and DONE.
- done, output, 1, one-cycle pulse; diff and bout are valid from this cycle on.
- diff, output, WIDTH, parallel difference (a - b) mod 2^WIDTH.
- bout, output, 1, final borrow; 1 when a < b (unsigned).
- diff_bit, output, 1, serial difference bit.
- diff_bit_valid, output, 1, qualifies diff_bit.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, and busy, done, diff, bout, diff_bit, diff_bit_valid, shift registers, borrow and count all 0. Reset asserted mid-operation aborts the operation immediately; no done pulse is produced.
- States are IDLE, RUN and DONE, all registered.
- IDLE, start=1 at an edge (edge 0):
  - load A_sr<=a, B_sr<=b, br<=0, cnt<=0;
  - state->RUN.
- IDLE, start=0: the block stays in IDLE.
- RUN, edge k = 1..WIDTH, processes bit i = k-1:
  - d = A_sr[0]^B_sr[0]^br;
  - br_next = (~A_sr[0]&B_sr[0]) | (~(A_sr[0]^B_sr[0])&br);
  - A_sr and B_sr shift right;
  - d shifts into the MSB of the result shift register;
  - diff_bit<=d, diff_bit_valid<=1, cnt<=cnt+1.
- At edge WIDTH (cnt==WIDTH-1):
  - diff<=completed result, bout<=br_next;
  - done<=1, state->DONE.
- DONE, next edge: done<=0, diff_bit_valid<=0, state->IDLE.
- Latency: done goes high exactly WIDTH clocks after the start-accepting edge. Throughput is one operation per WIDTH+2 cycles.
- diff_bit_valid is high for exactly WIDTH consecutive cycles. Its last valid cycle coincides with done.
- diff and bout hold their value until the next operation's DONE edge. They do not change at start.
- diff_bit holds its last value when not valid.
- start in RUN or DONE is ignored and not queued. a and b may change freely after the capture edge.
- Arithmetic is unsigned, mod 2^WIDTH. bout=1 iff a < b (or a < b+bin when the optional feature is compiled in). a == b gives diff=0, bout=0.
- The counter width is clog2(WIDTH)+1, so it never wraps within an operation.

Optional Feature:
- Macro: SERIAL_SUB_BIN_EN.
- With the macro defined:
  - adds port bin (input, 1), a borrow-in captured on the accepted start edge as the initial br;
  - result = a - b - bin, with bout being the borrow out of the MSB;
  - enables chaining of multi-word subtraction.
- Without the macro: the port is absent and the initial br is 0.

Test Plan:
- WIDTH=8, a=200, b=55, start pulse -> done exactly 8 clocks later, diff=145, bout=0, busy high for 9 cycles.
- a=55, b=200 -> diff=111 (0x6F), bout=1; a=0, b=1 -> diff=0xFF, bout=1; a=b=0x3C -> diff=0, bout=0.
- a=0xA5, b=0x00 -> serial diff_bit stream LSB first 1,0,1,0,0,1,0,1 over 8 valid cycles, with the last valid cycle coincident with done.
- start re-pulsed with a=9, b=1 during RUN of op 200-55 -> ignored, and a single done with diff=145; a back-to-back start in the cycle after done is accepted.
- rst_n driven low at clock 4 of an operation -> all outputs 0 asynchronously, no done pulse; the next start produces a correct result.
- With SERIAL_SUB_BIN_EN defined: a=10, b=3, bin=1 -> diff=6, bout=0; a=3, b=3, bin=1 -> diff=0xFF, bout=1.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor; bin exists only with SERIAL_SUB_BIN_EN.
// master drives start/operands, slave is the subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_BIN_EN
  logic             bin;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             diff_bit;
  logic             diff_bit_valid;

  modport master (
`ifdef SERIAL_SUB_BIN_EN
    output bin,
`endif
    output start, a, b,
    input  busy, done, diff, bout, diff_bit, diff_bit_valid
  );

  modport slave (
`ifdef SERIAL_SUB_BIN_EN
    input  bin,
`endif
    input  start, a, b,
    output busy, done, diff, bout, diff_bit, diff_bit_valid
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b (LSB first, one full-subtractor + registered borrow); SERIAL_SUB_BIN_EN adds borrow-in.
// Latency: done exactly WIDTH clocks after the accepting start edge; one op per WIDTH+2 cycles.
// Backpressure: none; start is only sampled in IDLE, ignored (not queued) while busy.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_subtractor_if.slave sub
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, a_sr_nxt;
  logic [WIDTH-1:0] b_sr, b_sr_nxt;
  logic [WIDTH-1:0] r_sr, r_sr_nxt;
  logic [WIDTH-1:0] diff_q, diff_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             br, br_nxt;
  logic             bout_q, bout_nxt;
  logic             done_q, done_nxt;
  logic             dbit_q, dbit_nxt;
  logic             dvld_q, dvld_nxt;
  logic             d, borrow;
  logic             bin_in;

`ifdef SERIAL_SUB_BIN_EN
  assign bin_in = sub.bin;
`else
  assign bin_in = 1'b0;
`endif

  always_comb begin
    d         = a_sr[0] ^ b_sr[0] ^ br;
    borrow    = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    state_nxt = state;
    a_sr_nxt  = a_sr;
    b_sr_nxt  = b_sr;
    r_sr_nxt  = r_sr;
    diff_nxt  = diff_q;
    cnt_nxt   = cnt;
    br_nxt    = br;
    bout_nxt  = bout_q;
    done_nxt  = done_q;
    dbit_nxt  = dbit_q;
    dvld_nxt  = dvld_q;
    case (state)
      IDLE: begin
        if (sub.start) begin
          a_sr_nxt  = sub.a;
          b_sr_nxt  = sub.b;
          br_nxt    = bin_in;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        a_sr_nxt = a_sr >> 1;
        b_sr_nxt = b_sr >> 1;
        r_sr_nxt = {d, r_sr[WIDTH-1:1]};
        br_nxt   = borrow;
        dbit_nxt = d;
        dvld_nxt = 1'b1;
        cnt_nxt  = cnt + CW'(1);
        // last bit: publish the completed word and the borrow out of the MSB
        if (cnt == CW'(WIDTH - 1)) begin
          diff_nxt  = {d, r_sr[WIDTH-1:1]};
          bout_nxt  = borrow;
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done_nxt  = 1'b0;
        dvld_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      diff_q <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      bout_q <= 1'b0;
      done_q <= 1'b0;
      dbit_q <= 1'b0;
      dvld_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      a_sr   <= a_sr_nxt;
      b_sr   <= b_sr_nxt;
      r_sr   <= r_sr_nxt;
      diff_q <= diff_nxt;
      cnt    <= cnt_nxt;
      br     <= br_nxt;
      bout_q <= bout_nxt;
      done_q <= done_nxt;
      dbit_q <= dbit_nxt;
      dvld_q <= dvld_nxt;
    end
  end

  assign sub.busy           = (state != IDLE);
  assign sub.done           = done_q;
  assign sub.diff           = diff_q;
  assign sub.bout           = bout_q;
  assign sub.diff_bit       = dbit_q;
  assign sub.diff_bit_valid = dvld_q;
endmodule
